// File: rtl/vga_sync_decoder.sv
// Receive-side 640x480 VGA timing decoder: recovers x/y/de, measures line and frame timing, tracks lock.
// Define VGA_DEC_CRC_EN to add a per-frame CRC-16-CCITT over active pixels (o_frame_crc, o_crc_valid).
module vga_sync_decoder #(
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_TOTAL      = 525,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [1:0]  i_r,
    input  logic [2:0]  i_g,
    input  logic [2:0]  i_b,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic        o_de,
    output logic [1:0]  o_r,
    output logic [2:0]  o_g,
    output logic [2:0]  o_b,
    output logic        o_pix_valid,
    output logic        o_locked,
    output logic [10:0] o_line_len,
    output logic [9:0]  o_frame_lines,
    output logic        o_hs_err,
`ifdef VGA_DEC_CRC_EN
    output logic [15:0] o_frame_crc,
    output logic        o_crc_valid,
`endif
    output logic        o_vs_err
);

    // state  | meaning
    // SEARCH | waiting for the first VS fall
    // TRACK  | counting consecutive error-free frames
    // LOCKED | timing stable, o_de enabled
    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  H_SS    = 10'(H_SYNC_START);
    localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
    localparam logic [10:0] H_TOT11 = 11'(H_TOTAL);
    localparam logic [10:0] H_TMO   = 11'(2 * H_TOTAL);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_SS    = 10'(V_SYNC_START);
    localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0]  V_TOT10 = 10'(V_TOTAL);
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

    state_t      state;
    logic        hs_q, vs_q;
    logic [9:0]  hcnt, vcnt;
    logic [10:0] llen;
    logic [9:0]  flines;
    logic [3:0]  good;
    logic        err_seen, h_armed, v_armed;

    logic        hs_fall, vs_fall, hwrap, tmo, hs_err_now, vs_err_now, de_nxt;
    logic [9:0]  hcnt_nxt, vcnt_nxt, flines_meas;
    logic [10:0] llen_inc;

    assign o_x = hcnt;
    assign o_y = vcnt;

    always_comb begin
        hs_fall  = i_pix_stb && hs_q && !i_hs;
        vs_fall  = i_pix_stb && vs_q && !i_vs;
        hwrap    = i_pix_stb && !hs_fall && (hcnt == H_LAST);
        hcnt_nxt = hs_fall ? H_SS : (hwrap ? 10'd0 : hcnt + 10'd1);
        vcnt_nxt = vcnt;
        if (vs_fall)
            vcnt_nxt = V_SS;
        else if (hwrap)
            vcnt_nxt = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        llen_inc    = (llen == 11'h7FF) ? llen : llen + 11'd1;
        tmo         = i_pix_stb && !hs_fall && (llen_inc == H_TMO);
        hs_err_now  = (hs_fall && h_armed && (llen != H_TOT11)) || tmo;
        // a wrap on the VS-fall strobe closes the frame that is ending
        flines_meas = (hwrap && (flines != 10'h3FF)) ? flines + 10'd1 : flines;
        vs_err_now  = vs_fall && v_armed && (flines_meas != V_TOT10);
        de_nxt      = (hcnt_nxt < H_ACT) && (vcnt_nxt < V_ACT) && (state == LOCKED);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state         <= SEARCH;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            hcnt          <= '0;
            vcnt          <= '0;
            llen          <= '0;
            flines        <= '0;
            good          <= '0;
            err_seen      <= 1'b0;
            h_armed       <= 1'b0;
            v_armed       <= 1'b0;
            o_de          <= 1'b0;
            o_r           <= '0;
            o_g           <= '0;
            o_b           <= '0;
            o_pix_valid   <= 1'b0;
            o_locked      <= 1'b0;
            o_line_len    <= '0;
            o_frame_lines <= '0;
            o_hs_err      <= 1'b0;
            o_vs_err      <= 1'b0;
        end else begin
            o_pix_valid <= i_pix_stb;
            o_hs_err    <= hs_err_now;
            o_vs_err    <= vs_err_now;
            if (i_pix_stb) begin
                hs_q <= i_hs;
                vs_q <= i_vs;
                hcnt <= hcnt_nxt;
                vcnt <= vcnt_nxt;
                o_r  <= i_r;
                o_g  <= i_g;
                o_b  <= i_b;
                o_de <= de_nxt;
                if (hs_fall) begin
                    o_line_len <= llen;
                    llen       <= 11'd1;
                    h_armed    <= 1'b1;
                end else if (tmo) begin
                    llen <= '0;
                end else begin
                    llen <= llen_inc;
                end
                if (vs_fall) begin
                    o_frame_lines <= flines_meas;
                    flines        <= '0;
                    v_armed       <= 1'b1;
                end else begin
                    flines <= flines_meas;
                end
            end
            case (state)
                SEARCH: begin
                    if (vs_fall) begin
                        state    <= TRACK;
                        good     <= '0;
                        err_seen <= 1'b0;
                    end
                end
                TRACK: begin
                    if (vs_fall) begin
                        err_seen <= 1'b0;
                        if (err_seen || hs_err_now || vs_err_now) begin
                            good <= '0;
                        end else begin
                            good <= good + 4'd1;
                            if (good + 4'd1 >= LOCK_N) begin
                                state    <= LOCKED;
                                o_locked <= 1'b1;
                            end
                        end
                    end else if (hs_err_now) begin
                        good     <= '0;
                        err_seen <= 1'b1;
                    end
                end
                LOCKED: begin
                    // react to the registered pulse so o_locked drops one clock after it
                    if (o_hs_err || o_vs_err) begin
                        state    <= SEARCH;
                        o_locked <= 1'b0;
                        o_de     <= 1'b0;
                        h_armed  <= 1'b0;
                        v_armed  <= 1'b0;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

`ifdef VGA_DEC_CRC_EN
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i])
                r = {r[14:0], 1'b0} ^ 16'h1021;
            else
                r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    logic [15:0] crc_acc;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            crc_acc     <= 16'hFFFF;
            o_frame_crc <= '0;
            o_crc_valid <= 1'b0;
        end else begin
            o_crc_valid <= vs_fall;
            if (vs_fall) begin
                o_frame_crc <= crc_acc;
                crc_acc     <= 16'hFFFF;
            end else if (i_pix_stb && de_nxt) begin
                crc_acc <= crc_byte(crc_acc, {i_r, i_g, i_b});
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down timing (24x14) driven by a simple generator.
// Define VGA_DEC_CRC_EN to also exercise the frame CRC outputs.
module tb_vga_sync_decoder;

    localparam int H_A  = 16;
    localparam int H_SS = 18;
    localparam int H_SE = 22;
    localparam int H_T  = 24;
    localparam int V_A  = 8;
    localparam int V_SS = 10;
    localparam int V_SE = 12;
    localparam int V_T  = 14;
    localparam int FRAME = H_T * V_T;

    logic        i_clk, i_rst, i_pix_stb, i_hs, i_vs;
    logic [1:0]  i_r;
    logic [2:0]  i_g, i_b;
    logic [9:0]  o_x, o_y, o_frame_lines;
    logic        o_de, o_pix_valid, o_locked, o_hs_err, o_vs_err;
    logic [1:0]  o_r;
    logic [2:0]  o_g, o_b;
    logic [10:0] o_line_len;
`ifdef VGA_DEC_CRC_EN
    logic [15:0] o_frame_crc;
    logic        o_crc_valid;
    logic        snap_crc_valid;
    logic [15:0] crc_exp;
`endif

    vga_sync_decoder #(
        .H_ACTIVE(H_A), .H_SYNC_START(H_SS), .H_TOTAL(H_T),
        .V_ACTIVE(V_A), .V_SYNC_START(V_SS), .V_TOTAL(V_T), .LOCK_FRAMES(2)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb),
        .i_hs(i_hs), .i_vs(i_vs), .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .o_x(o_x), .o_y(o_y), .o_de(o_de), .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_pix_valid(o_pix_valid), .o_locked(o_locked),
        .o_line_len(o_line_len), .o_frame_lines(o_frame_lines),
        .o_hs_err(o_hs_err),
`ifdef VGA_DEC_CRC_EN
        .o_frame_crc(o_frame_crc), .o_crc_valid(o_crc_valid),
`endif
        .o_vs_err(o_vs_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int gx = 0, gy = 0, last_x = 0, last_y = 0;
    int short_y = -1, hs_skip_y = -1;
    bit zero_px = 1'b0;
    logic snap_hs_err, snap_locked;
    int hs_err_cnt = 0, vs_err_cnt = 0, de_cnt = 0, hs_base = 0;

    always @(negedge i_clk) begin
        if (o_hs_err) hs_err_cnt++;
        if (o_vs_err) vs_err_cnt++;
        if (o_pix_valid && o_de) de_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // emit the generator's current pixel on one strobe, then advance it
    task automatic step();
        logic [7:0] c;
        i_hs = !((gx >= H_SS) && (gx < H_SE) && (gy != hs_skip_y));
        i_vs = !((gy >= V_SS) && (gy < V_SE));
        if (zero_px)
            c = 8'h00;
        else if (gx == 5 && gy == 3)
            c = 8'hC0;
        else
            c = 8'(gx * 7 + gy * 3 + 1);
        {i_r, i_g, i_b} = c;
        i_pix_stb = 1'b1;
        @(posedge i_clk); #1;
        snap_hs_err = o_hs_err;
        snap_locked = o_locked;
`ifdef VGA_DEC_CRC_EN
        snap_crc_valid = o_crc_valid;
`endif
        i_pix_stb = 1'b0;
        @(posedge i_clk); #1;
        last_x = gx;
        last_y = gy;
        if (gx == ((gy == short_y) ? H_T - 2 : H_T - 1)) begin
            gx = 0;
            gy = (gy == V_T - 1) ? 0 : gy + 1;
        end else begin
            gx++;
        end
    endtask

    task automatic run_until(input int tx, input int ty);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(last_x == tx && last_y == ty) && n < 2 * FRAME);
        chk("reach_pos", 32'(last_x * 1000 + last_y), 32'(tx * 1000 + ty));
    endtask

    function automatic logic [15:0] crc_ref(input int nbytes, input logic [7:0] val);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int n = 0; n < nbytes; n++) begin
            c = c ^ {val, 8'h00};
            for (int k = 0; k < 8; k++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    initial begin
        i_rst = 1'b0; i_pix_stb = 1'b0; i_hs = 1'b1; i_vs = 1'b1;
        i_r = '0; i_g = '0; i_b = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_x", 32'(o_x), 0);
        chk("rst_locked", 32'(o_locked), 0);
        chk("rst_line_len", 32'(o_line_len), 0);
        chk("rst_pix_valid", 32'(o_pix_valid), 0);
        i_rst = 1'b1;

        // acquisition: lock at the third VS fall
        run_until(0, V_SS);
        chk("lock_vs1", 32'(o_locked), 0);
        run_until(0, V_SS);
        chk("lock_vs2", 32'(o_locked), 0);
        chk("frame_lines", 32'(o_frame_lines), V_T);
        run_until(H_T - 1, V_SS - 1);
        chk("lock_before_vs3", 32'(o_locked), 0);
        step();
        chk("lock_vs3", 32'(o_locked), 1);
        chk("line_len", 32'(o_line_len), H_T);

        run_until(H_T - 1, V_T - 1);
        de_cnt = 0;
        run_until(H_T - 1, V_T - 1);
        chk("de_count", 32'(de_cnt), H_A * V_A);
        chk("hs_err_clean", 32'(hs_err_cnt), 0);
        chk("vs_err_clean", 32'(vs_err_cnt), 0);

        // pixel recovery and de boundaries
        run_until(5, 3);
        chk("px_x", 32'(o_x), 5);
        chk("px_y", 32'(o_y), 3);
        chk("px_de", 32'(o_de), 1);
        chk("px_r", 32'(o_r), 3);
        chk("px_g", 32'(o_g), 0);
        chk("px_b", 32'(o_b), 0);
        run_until(H_A, 3);
        chk("de_x_edge", 32'(o_de), 0);
        run_until(H_A - 1, V_A - 1);
        chk("de_last_active", 32'(o_de), 1);
        run_until(0, V_A);
        chk("de_y_edge", 32'(o_de), 0);

        // one short line while locked
        run_until(H_T - 1, V_T - 1);
        short_y = 5;
        hs_base = hs_err_cnt;
        run_until(H_SS, 6);
        short_y = -1;
        chk("short_err_pulse", 32'(snap_hs_err), 1);
        chk("short_locked_same_clk", 32'(snap_locked), 1);
        chk("short_unlock", 32'(o_locked), 0);
        chk("short_line_len", 32'(o_line_len), H_T - 1);
        run_until(0, V_SS);
        chk("relock_vs1", 32'(o_locked), 0);
        run_until(0, V_SS);
        chk("relock_vs2", 32'(o_locked), 0);
        run_until(0, V_SS);
        chk("relock_vs3", 32'(o_locked), 1);
        chk("short_err_count", 32'(hs_err_cnt - hs_base), 1);

        // HS missing for one line: timeout after 2*H_T strobes
        run_until(H_T - 1, V_T - 1);
        hs_skip_y = 2;
        hs_base = hs_err_cnt;
        run_until(16, 3);
        chk("tmo_none_yet", 32'(hs_err_cnt - hs_base), 0);
        chk("tmo_still_locked", 32'(o_locked), 1);
        step();
        chk("tmo_pulse", 32'(snap_hs_err), 1);
        chk("tmo_line_len_kept", 32'(o_line_len), H_T);
        chk("tmo_unlock", 32'(o_locked), 0);
        hs_skip_y = -1;
        run_until(H_T - 1, 5);
        chk("tmo_err_count", 32'(hs_err_cnt - hs_base), 1);

        // asynchronous reset mid-frame
        run_until(0, V_SS);
        run_until(0, V_SS);
        run_until(0, V_SS);
        chk("pre_rst_locked", 32'(o_locked), 1);
        run_until(7, 4);
        #3;
        i_rst = 1'b0;
        #1;
        chk("arst_locked", 32'(o_locked), 0);
        chk("arst_x", 32'(o_x), 0);
        chk("arst_y", 32'(o_y), 0);
        chk("arst_g", 32'(o_g), 0);
        chk("arst_line_len", 32'(o_line_len), 0);
        chk("arst_frame_lines", 32'(o_frame_lines), 0);
        @(posedge i_clk); #2;
        i_rst = 1'b1;
        run_until(0, V_SS);
        chk("rst_relock_vs1", 32'(o_locked), 0);
        run_until(0, V_SS);
        chk("rst_relock_vs2", 32'(o_locked), 0);
        run_until(0, V_SS);
        chk("rst_relock_vs3", 32'(o_locked), 1);

`ifdef VGA_DEC_CRC_EN
        zero_px = 1'b1;
        crc_exp = crc_ref(H_A * V_A, 8'h00);
        run_until(0, V_SS);
        chk("crc_valid1", 32'(snap_crc_valid), 1);
        chk("crc_frame1", 32'(o_frame_crc), 32'(crc_exp));
        run_until(0, V_SS);
        chk("crc_valid2", 32'(snap_crc_valid), 1);
        chk("crc_frame2", 32'(o_frame_crc), 32'(crc_exp));
        zero_px = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
